// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle for the sequential binary-to-BCD converter.
//   Parameters W (binary width) and D (BCD digit count) must match the converter.
//   i_start : conversion request (requester -> converter)
//   i_bin   : W-bit unsigned value, sampled on the accepting edge
//   o_busy  : conversion in progress
//   o_done  : one-cycle pulse when o_bcd/o_ovf are updated
//   o_bcd   : 4*D-bit result, digit k at [4k+3:4k]
//   o_ovf   : value did not fit in D digits
//   o_seg   : 7*D-bit segment patterns {g,f,e,d,c,b,a} per digit; this signal
//             exists only when BIN2BCD_SEG_EN is defined
// The master modport is the requester side; the slave modport is the converter side.
interface bin2bcd_seq_if #(
   parameter int unsigned W = 8,
   parameter int unsigned D = 3
) ();
   logic           i_start;
   logic [W-1:0]   i_bin;
   logic           o_busy;
   logic           o_done;
   logic [4*D-1:0] o_bcd;
   logic           o_ovf;
`ifdef BIN2BCD_SEG_EN
   logic [7*D-1:0] o_seg;

   modport master (output i_start, i_bin, input o_busy, o_done, o_bcd, o_ovf, o_seg);
   modport slave  (input i_start, i_bin, output o_busy, o_done, o_bcd, o_ovf, o_seg);
`else
   modport master (output i_start, i_bin, input o_busy, o_done, o_bcd, o_ovf);
   modport slave  (input i_start, i_bin, output o_busy, o_done, o_bcd, o_ovf);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double dabble, one bit per clock).
//   W-bit unsigned input is converted to D BCD digits in W cycles after acceptance.
//   The result and overflow flag are held until the next conversion completes.
// Ports:
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : bin2bcd_seq_if.slave (i_start, i_bin, o_busy, o_done, o_bcd, o_ovf[, o_seg])
// Optional feature:
//   BIN2BCD_SEG_EN defined -> o_seg carries registered seven-segment patterns of the
//   result digits, updated on the same edge as o_bcd.
module bin2bcd_seq #(
   parameter int unsigned W = 8,
   parameter int unsigned D = 3
) (
   input  logic          i_clk,
   input  logic          i_rst,
   bin2bcd_seq_if.slave  bus
);
   localparam int unsigned WR = 4*D + W;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t         r_state, w_state_nxt;
   logic [WR-1:0]  r_work;
   logic [WR-1:0]  w_adj;
   logic [WR-1:0]  w_shift;
   logic [5:0]     r_cnt;
   logic           r_acc;
   logic           r_done;
   logic           r_ovf;
   logic [4*D-1:0] r_bcd;
   logic           w_load;
   logic           w_iter;
   logic           w_last;

   // Digits sit above the binary field; add 3 to any digit >= 5, then shift.
   always_comb begin
      w_adj = r_work;
      for (int unsigned k = 0; k < D; k++) begin
         if (r_work[W+4*k +: 4] >= 4'd5)
            w_adj[W+4*k +: 4] = r_work[W+4*k +: 4] + 4'd3;
      end
      w_shift = {w_adj[WR-2:0], 1'b0};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_iter      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.i_start) begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_iter = 1'b1;
            if (r_cnt == 6'd1) begin
               w_last      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef BIN2BCD_SEG_EN
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1101111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   logic [7*D-1:0] r_seg;
   logic [7*D-1:0] w_seg;

   // Decoded from the post-shift digits so the pattern registers with o_bcd.
   always_comb begin
      w_seg = '0;
      for (int unsigned k = 0; k < D; k++)
         w_seg[7*k +: 7] = seg7(w_shift[W+4*k +: 4]);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       r_seg <= {D{7'b0111111}};
      else if (w_last) r_seg <= w_seg;
   end

   assign bus.o_seg = r_seg;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_work <= '0;
         r_cnt  <= '0;
         r_acc  <= 1'b0;
         r_done <= 1'b0;
         r_bcd  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_load) begin
            r_work <= WR'(bus.i_bin);
            r_cnt  <= 6'(W);
            r_acc  <= 1'b0;
         end else if (w_iter) begin
            r_work <= w_shift;
            r_cnt  <= r_cnt - 6'd1;
            r_acc  <= r_acc | w_adj[WR-1];
            if (w_last) begin
               // Include the bit leaving on this final shift.
               r_bcd <= w_shift[W +: 4*D];
               r_ovf <= r_acc | w_adj[WR-1];
            end
         end
      end
   end

   assign bus.o_busy = (r_state == S_SHIFT);
   assign bus.o_done = r_done;
   assign bus.o_bcd  = r_bcd;
   assign bus.o_ovf  = r_ovf;
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It replaces fixed-width combinational converters feeding the seven-segment display path, so arbitrary adder/counter result widths can be shown as D decimal digits. Requests use a start/busy/done handshake, and the result is held until the next conversion. A sticky-per-conversion overflow flag reports values that do not fit in D digits.

## Interface
- W, default 8: binary input width; legal range 1..32.
- D, default 3: number of BCD digits produced; legal range 1..10.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only while busy=0.
- bin  input  W  unsigned binary value; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd/ovf are updated.
- bcd  output  4*D  result; digit k at bits [4k+3:4k], digit 0 = ones.
- ovf  output  1  value ≥ 10^D; valid with done, held with bcd.
- seg  output  7*D  present only with BIN2BCD_SEG_EN (see Configuration).

## Operation
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1, iteration counter runs W..1.
- IDLE → SHIFT: on an edge with start=1. Load work register {digits=0, bin}, clear internal overflow accumulator, counter=W. No shift occurs on the load edge.
- SHIFT iteration, one per edge:
  - Add 3 to every work digit ≥5.
  - Shift the {digits, binary} register left by 1.
  - Any 1 shifted out of the top digit sets the overflow accumulator.
  - Decrement the counter.
- Final iteration (counter=1):
  - Load bcd with the final digits and ovf with the accumulator.
  - Assert done for exactly one cycle; return to IDLE.
- Overflow result: bcd = bin mod 10^D (low digits are exact), ovf=1.
- start while busy=1: ignored; no queuing.
- start in the cycle done=1: accepted (busy=0), so conversions can run back-to-back.
- bcd/ovf change only on the final-iteration edge; they are stable throughout SHIFT.
- Every digit of bcd is always 0..9.

## Timing
- Accept edge E0: busy=1 after E0.
- Iterations occur on edges E1..EW.
- After EW: bcd/ovf valid, done=1, busy=0.
- Latency: W cycles from the accept edge to done. Throughput: one conversion per W cycles.
- done falls after EW+1.
- Reset values: busy=0, done=0, bcd=0, ovf=0, seg = digit "0" pattern on every digit, state IDLE.
- Reset during SHIFT aborts immediately and asynchronously to the reset values. No done is produced for the aborted request.
- W=1: a single iteration, done after E1.

## Configuration
- BIN2BCD_SEG_EN defined:
  - The seg port exists: per digit, 7 active-high segments {g,f,e,d,c,b,a} at bits [7k+6:7k].
  - Decoded from the final digits and registered on the same edge as bcd, so there is no extra latency.
  - Digit 0 = 7'b0111111, 1 = 7'b0000110, 9 = 7'b1101111.
- BIN2BCD_SEG_EN undefined:
  - No seg port and no decode logic.
  - All other behaviour is identical.

## Test plan
- W=8, D=3, bin=8'hFF, start pulse: done exactly 8 cycles after accept, bcd=12'h255, ovf=0, busy high for 8 cycles.
- W=8, D=3, bin=0, then back-to-back start on the done cycle with bin=8'd99: bcd=12'h000, then 12'h099 after 8 more cycles. No idle cycle between conversions.
- W=5, D=2, sweep bin=0..31: bcd equals the decimal value, e.g. 31 → 8'h31, 10 → 8'h10, ovf=0 throughout.
- W=8, D=2:
  - bin=99 → bcd=8'h99, ovf=0.
  - bin=100 → bcd=8'h00, ovf=1.
  - bin=200 → bcd=8'h00, ovf=1.
- During a conversion of 8'd123:
  - Pulse start with bin=45 at cycle 3: ignored, result is 12'h123.
  - Assert rst at cycle 5: busy/done/bcd=0 immediately, no done pulse. A new start after reset converts correctly.
- With BIN2BCD_SEG_EN, W=8, D=3, bin=8'd190:
  - seg[6:0]=7'b0111111 ("0"), seg[13:7]=7'b1101111 ("9"), seg[20:14]=7'b0000110 ("1").
  - seg updates on the same edge as bcd.
